wavelet_fir_mac: RTL

Serial multiply-accumulate filter stage that sits directly downstream of the tap shift register line. It consumes the packed `o_taps` vector whenever the line strobes a new sample. Each tap is multiplied by a fixed signed wavelet coefficient, one tap per clock, and the products are summed into a wide accumulator. The block emits one scaled, width-reduced filter output with a single-cycle valid pulse.

---
 rtl/wavelet_fir_mac.sv | 125 ++++++++++++
 1 files changed

// File: rtl/wavelet_fir_mac.sv
// Serial wavelet FIR MAC: one tap*coef product per clock into a wide accumulator, then scale and narrow.
// Latency: TOTAL_TAPS+1 cycles from an accepted i_start to the o_valid pulse (10 with defaults).
// Backpressure: none; i_start while o_busy is dropped. Optional clamp: define WAVELET_FIR_SAT_EN.
module wavelet_fir_mac #(
  parameter int TOTAL_TAPS   = 9,
  parameter int BITS_PER_TAP = 8,
  parameter int TOTAL_BITS   = 9*8,
  parameter int COEF_BITS    = 8,
  parameter logic [TOTAL_TAPS*COEF_BITS-1:0] COEFFS =
    {TOTAL_TAPS{{(COEF_BITS-1){1'b0}}, 1'b1}},
  parameter int SHIFT        = 0,
  parameter int OUT_BITS     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [TOTAL_BITS-1:0] i_taps,
  output logic [OUT_BITS-1:0]   o_value,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_sat
);

  localparam int PROD_BITS = BITS_PER_TAP + COEF_BITS;
  localparam int ACC_BITS  = PROD_BITS + $clog2(TOTAL_TAPS);
  localparam int IDX_BITS  = (TOTAL_TAPS > 1) ? $clog2(TOTAL_TAPS) : 1;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(TOTAL_TAPS - 1);

  // Catch a mismatched packed-tap width at elaboration rather than silently mis-slicing.
  if (TOTAL_BITS != TOTAL_TAPS * BITS_PER_TAP) begin : g_bad_width
    $error("wavelet_fir_mac: TOTAL_BITS must equal TOTAL_TAPS*BITS_PER_TAP");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                      state;
  logic [IDX_BITS-1:0]         idx;
  logic [TOTAL_BITS-1:0]       taps_q;
  logic signed [ACC_BITS-1:0]  acc;
  logic                        sat_q;

  logic signed [BITS_PER_TAP-1:0] tap_sel;
  logic signed [COEF_BITS-1:0]    coef_sel;
  logic signed [PROD_BITS-1:0]    prod;
  logic signed [ACC_BITS-1:0]     prod_ext;
  logic signed [ACC_BITS-1:0]     shifted;
  logic [OUT_BITS-1:0]            value_next;
  logic                           sat_next;

  assign tap_sel  = taps_q[idx*BITS_PER_TAP +: BITS_PER_TAP];
  assign coef_sel = COEFFS[idx*COEF_BITS +: COEF_BITS];
  assign prod     = tap_sel * coef_sel;
  assign prod_ext = ACC_BITS'(prod);
  // Arithmetic shift: negative sums round toward minus infinity.
  assign shifted  = acc >>> SHIFT;

`ifdef WAVELET_FIR_SAT_EN
  localparam int EXT_BITS = (ACC_BITS > OUT_BITS) ? ACC_BITS : OUT_BITS;
  localparam logic signed [EXT_BITS-1:0] OUT_MAX = EXT_BITS'(2**(OUT_BITS-1) - 1);
  localparam logic signed [EXT_BITS-1:0] OUT_MIN = ~OUT_MAX;

  logic signed [EXT_BITS-1:0] shifted_ext;
  assign shifted_ext = EXT_BITS'(shifted);

  // Clamp the scaled sum into the signed output range and flag when it was clipped.
  always_comb begin
    sat_next   = 1'b0;
    value_next = OUT_BITS'(shifted_ext);
    if (shifted_ext > OUT_MAX) begin
      sat_next   = 1'b1;
      value_next = OUT_BITS'(OUT_MAX);
    end else if (shifted_ext < OUT_MIN) begin
      sat_next   = 1'b1;
      value_next = OUT_BITS'(OUT_MIN);
    end
  end
`else
  // Plain two's-complement wrap: keep the low output bits, never flag.
  assign value_next = OUT_BITS'(shifted);
  assign sat_next   = 1'b0;
`endif

  assign o_sat = sat_q;

  // Control FSM with datapath registers; outputs are all registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      acc     <= '0;
      taps_q  <= '0;
      o_value <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            taps_q <= i_taps;
            acc    <= '0;
            idx    <= '0;
            o_busy <= 1'b1;
            state  <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc <= acc + prod_ext;
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) state <= S_DONE;
        end
        S_DONE: begin
          o_value <= value_next;
          sat_q   <= sat_next;
          o_valid <= 1'b1;
          o_busy  <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
